// File: rtl/uvmt_reset_st_rst_gen_pkg.sv
// Shared types and helpers for the reset-pulse generator.
// The pulse duration clamp lives here so the RTL and its users agree on it.
package uvmt_reset_st_rst_gen_pkg;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        ASSERT = 2'd2,
        SETTLE = 2'd3
    } state_t;

    // Effective pulse length: requests shorter than min_cycles are stretched.
    function automatic logic [31:0] eff_dur(input logic [31:0] dur, input logic [31:0] min_cycles);
        return (dur < min_cycles) ? min_cycles : dur;
    endfunction

endpackage

// File: rtl/uvmt_reset_st_rst_gen.sv
// Reset-pulse generator: holds reset after power-up, then emits requested
// pulses of a programmed length, each followed by a quiet settle window.
module uvmt_reset_st_rst_gen
    import uvmt_reset_st_rst_gen_pkg::*;
#(
    parameter int DUR_W         = 16,
    parameter int CNT_W         = 8,
    parameter int INIT_CYCLES   = 8,
    parameter int MIN_CYCLES    = 2,
    parameter int SETTLE_CYCLES = 4,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [DUR_W-1:0] req_duration,
    output logic             reset_o,
    output logic             rst_active,
    output logic             done,
    output logic [CNT_W-1:0] pulse_count,
    output logic             clamped
);

    localparam int MAX_P = (INIT_CYCLES > MIN_CYCLES)
                         ? ((INIT_CYCLES > SETTLE_CYCLES) ? INIT_CYCLES : SETTLE_CYCLES)
                         : ((MIN_CYCLES > SETTLE_CYCLES) ? MIN_CYCLES : SETTLE_CYCLES);
    localparam int P_W   = $clog2(MAX_P + 1);
    // One spare bit so a full-scale duration never wraps the counter.
    localparam int CW    = ((DUR_W > P_W) ? DUR_W : P_W) + 1;

    localparam logic          ASSERTED  = (ACTIVE_LOW != 0) ? 1'b0 : 1'b1;
    localparam logic [CW-1:0] INIT_LD   = CW'(INIT_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LD = CW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          init_pass;
    logic          hs;
    logic          act_nxt, ready_nxt, done_nxt, clamp_nxt;

    assign hs = req_valid && req_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= INIT;
            cnt       <= INIT_LD;
            init_pass <= 1'b1;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state_nxt == IDLE)
                init_pass <= 1'b0;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            INIT, ASSERT: begin
                if (cnt == '0) begin
                    if (SETTLE_CYCLES > 0) begin
                        state_nxt = SETTLE;
                        cnt_nxt   = SETTLE_LD;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            IDLE: begin
                if (hs) begin
                    state_nxt = ASSERT;
                    cnt_nxt   = CW'(eff_dur(32'(req_duration), 32'(MIN_CYCLES)) - 32'd1);
                end
            end
            SETTLE: begin
                if (cnt == '0)
                    state_nxt = IDLE;
                else
                    cnt_nxt = cnt - 1'b1;
            end
            default: begin
                state_nxt = INIT;
                cnt_nxt   = INIT_LD;
            end
        endcase
    end

    // Outputs are computed from the upcoming state and registered below.
    always_comb begin
        act_nxt   = (state_nxt == INIT) || (state_nxt == ASSERT);
        ready_nxt = (state_nxt == IDLE);
        done_nxt  = (state != IDLE) && (state_nxt == IDLE) && !init_pass;
        clamp_nxt = (state == IDLE) && hs && (32'(req_duration) < 32'(MIN_CYCLES));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            reset_o     <= ASSERTED;
            rst_active  <= 1'b1;
            req_ready   <= 1'b0;
            done        <= 1'b0;
            clamped     <= 1'b0;
            pulse_count <= '0;
        end else begin
            reset_o    <= act_nxt ? ASSERTED : ~ASSERTED;
            rst_active <= act_nxt;
            req_ready  <= ready_nxt;
            done       <= done_nxt;
            clamped    <= clamp_nxt;
            if (done_nxt && (pulse_count != '1))
                pulse_count <= pulse_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_uvmt_reset_st_rst_gen.sv
// Directed bench for the reset-pulse generator: a default instance plus a
// CNT_W=2 instance sharing the same stimulus to observe counter saturation.
module tb_uvmt_reset_st_rst_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic [15:0] req_duration;

    logic       req_ready, reset_o, rst_active, done, clamped;
    logic [7:0] pulse_count;
    logic       s_req_ready, s_reset_o, s_rst_active, s_done, s_clamped;
    logic [1:0] s_pulse_count;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [15:0] dur;
        bit          clamp;
        int          len;
    } vec_t;

    vec_t vecs[5];

    always #5 clk = ~clk;

    uvmt_reset_st_rst_gen dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_duration(req_duration), .reset_o(reset_o), .rst_active(rst_active),
        .done(done), .pulse_count(pulse_count), .clamped(clamped)
    );

    uvmt_reset_st_rst_gen #(.CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(s_req_ready),
        .req_duration(req_duration), .reset_o(s_reset_o), .rst_active(s_rst_active),
        .done(s_done), .pulse_count(s_pulse_count), .clamped(s_clamped)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Called on the negedge right after the last reset edge, with reset just dropped.
    task automatic init_seq();
        int n = 0;
        int m = 0;
        int stray = 0;
        while (reset_o == 1'b0 && n < 100) begin
            if (done) stray++;
            n++;
            @(negedge clk);
        end
        chk("init_len", n, 8);
        while (reset_o == 1'b1 && !req_ready && m < 100) begin
            if (done) stray++;
            m++;
            @(negedge clk);
        end
        chk("init_settle", m, 4);
        chk("init_ready", req_ready, 1);
        chk("init_done", done, 0);
        chk("init_stray_done", stray, 0);
        chk("init_count", pulse_count, 0);
        chk("init_rst_active", rst_active, 0);
    endtask

    // Issue one request and follow it to its done cycle (ends on that negedge).
    task automatic run_pulse(input logic [15:0] dur, input bit exp_clamp, input int exp_len, input bit keep);
        int w = 0;
        int n = 0;
        int m = 0;
        int stray = 0;
        int exp_sat;
        req_valid    = 1'b1;
        req_duration = dur;
        while (!req_ready && w < 1000) begin
            w++;
            @(negedge clk);
        end
        @(negedge clk);
        if (!keep) req_valid = 1'b0;
        chk("pulse_start", reset_o, 0);
        chk("pulse_clamped", clamped, exp_clamp);
        chk("pulse_rst_active", rst_active, 1);
        while (reset_o == 1'b0 && n < 1000) begin
            if (done) stray++;
            n++;
            @(negedge clk);
        end
        chk("pulse_len", n, exp_len);
        while (reset_o == 1'b1 && !req_ready && m < 100) begin
            if (done) stray++;
            m++;
            @(negedge clk);
        end
        chk("settle_len", m, 4);
        exp_cnt++;
        exp_sat = (exp_cnt > 3) ? 3 : exp_cnt;
        chk("pulse_done", done, 1);
        chk("pulse_ready", req_ready, 1);
        chk("stray_done", stray, 0);
        chk("pulse_count", pulse_count, exp_cnt);
        chk("pulse_count_sat", s_pulse_count, exp_sat);
    endtask

    initial begin
        vecs[0] = '{dur: 16'd5,   clamp: 1'b0, len: 5};
        vecs[1] = '{dur: 16'd0,   clamp: 1'b1, len: 2};
        vecs[2] = '{dur: 16'd1,   clamp: 1'b1, len: 2};
        vecs[3] = '{dur: 16'd2,   clamp: 1'b0, len: 2};
        vecs[4] = '{dur: 16'd300, clamp: 1'b0, len: 300};

        reset        = 1'b1;
        req_valid    = 1'b0;
        req_duration = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_reset_o", reset_o, 0);
        chk("rst_rst_active", rst_active, 1);
        chk("rst_ready", req_ready, 0);
        chk("rst_done", done, 0);
        chk("rst_clamped", clamped, 0);
        chk("rst_count", pulse_count, 0);
        reset = 1'b0;
        init_seq();

        for (int i = 0; i < 5; i++)
            run_pulse(vecs[i].dur, vecs[i].clamp, vecs[i].len, 1'b0);

        // Request held high through a busy pulse: only one handshake per ready window.
        run_pulse(16'd6, 1'b0, 6, 1'b1);
        run_pulse(16'd3, 1'b0, 3, 1'b0);
        @(negedge clk);
        chk("done_one_cycle", done, 0);
        chk("clamped_one_cycle", clamped, 0);

        // Reset in the third cycle of a 10-cycle pulse.
        req_valid    = 1'b1;
        req_duration = 16'd10;
        @(negedge clk);
        req_valid = 1'b0;
        chk("mid_start", reset_o, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_reset_o", reset_o, 0);
        chk("mid_done", done, 0);
        chk("mid_ready", req_ready, 0);
        chk("mid_count", pulse_count, 0);
        chk("mid_count_sat", s_pulse_count, 0);
        init_seq();
        exp_cnt = 0;

        for (int i = 0; i < 5; i++)
            run_pulse(16'd2, 1'b0, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
